// File: rtl/free_list_if.sv
// Rename-stage free-list port bundle: allocation, commit/release and recovery signals.
// With FREE_LIST_PERF_CNT_EN defined the bundle also carries the stall_cnt counter.
`ifndef PRF_NUM
`define PRF_NUM 64
`endif
`ifndef PREG_INDEX_WIDTH
`define PREG_INDEX_WIDTH 6
`endif

interface free_list_if #(
    parameter int ARCH_REG_NUM = 32
);
    localparam int FL_DEPTH = `PRF_NUM - ARCH_REG_NUM;
    localparam int CNT_W    = $clog2(FL_DEPTH) + 1;
    localparam int PW       = `PREG_INDEX_WIDTH;

    logic [3:0]       alloc_req_vec;
    logic             alloc_ready;
    logic [PW-1:0]    alloc_preg_0;
    logic [PW-1:0]    alloc_preg_1;
    logic [PW-1:0]    alloc_preg_2;
    logic [PW-1:0]    alloc_preg_3;
    logic [3:0]       commit_rd_vec;
    logic [3:0]       free_vec;
    logic [PW-1:0]    free_preg_0;
    logic [PW-1:0]    free_preg_1;
    logic [PW-1:0]    free_preg_2;
    logic [PW-1:0]    free_preg_3;
    logic             recover_valid;
    logic [CNT_W-1:0] free_count;
`ifdef FREE_LIST_PERF_CNT_EN
    logic [31:0]      stall_cnt;
`endif

    modport master (
`ifdef FREE_LIST_PERF_CNT_EN
        input  stall_cnt,
`endif
        output alloc_req_vec, commit_rd_vec, free_vec, recover_valid,
        output free_preg_0, free_preg_1, free_preg_2, free_preg_3,
        input  alloc_ready, free_count,
        input  alloc_preg_0, alloc_preg_1, alloc_preg_2, alloc_preg_3
    );

    modport slave (
`ifdef FREE_LIST_PERF_CNT_EN
        output stall_cnt,
`endif
        input  alloc_req_vec, commit_rd_vec, free_vec, recover_valid,
        input  free_preg_0, free_preg_1, free_preg_2, free_preg_3,
        output alloc_ready, free_count,
        output alloc_preg_0, alloc_preg_1, alloc_preg_2, alloc_preg_3
    );
endinterface

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO with speculative/architectural heads and a tail.
// Optional stall counter enabled by defining FREE_LIST_PERF_CNT_EN.
`ifndef PRF_NUM
`define PRF_NUM 64
`endif
`ifndef PREG_INDEX_WIDTH
`define PREG_INDEX_WIDTH 6
`endif

module free_list #(
    parameter int ARCH_REG_NUM = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    free_list_if.slave fl
);
    localparam int FL_DEPTH = `PRF_NUM - ARCH_REG_NUM;
    localparam int PTR_W    = $clog2(FL_DEPTH);
    localparam int CNT_W    = $clog2(FL_DEPTH) + 1;
    localparam int PW       = `PREG_INDEX_WIDTH;

    typedef struct packed {
        logic             wrap;
        logic [PTR_W-1:0] idx;
    } ptr_t;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    function automatic logic [3:0] below(input int lane);
        return (4'b0001 << lane) - 4'b0001;
    endfunction

    function automatic logic [PTR_W-1:0] idx_add(input logic [PTR_W-1:0] idx, input logic [2:0] n);
        logic [PTR_W+1:0] sum;
        sum = (PTR_W+2)'(idx) + (PTR_W+2)'(n);
        if (sum >= (PTR_W+2)'(FL_DEPTH)) begin
            sum = sum - (PTR_W+2)'(FL_DEPTH);
        end else begin
            sum = sum;
        end
        return PTR_W'(sum);
    endfunction

    // A step smaller than the depth wraps exactly when the index lands below where it started.
    function automatic ptr_t ptr_add(input ptr_t p, input logic [2:0] n);
        ptr_t r;
        r.idx  = idx_add(p.idx, n);
        r.wrap = (r.idx < p.idx) ? ~p.wrap : p.wrap;
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] ptr_dist(input ptr_t t, input ptr_t h);
        if (t.wrap != h.wrap) begin
            return CNT_W'(FL_DEPTH) + CNT_W'(t.idx) - CNT_W'(h.idx);
        end else begin
            return CNT_W'(t.idx) - CNT_W'(h.idx);
        end
    endfunction

    logic [PW-1:0]    entries_q [FL_DEPTH];
    logic [PW-1:0]    entries_d [FL_DEPTH];
    ptr_t             head_q, head_d;
    ptr_t             arch_head_q, arch_head_d;
    ptr_t             tail_q, tail_d;
    logic [CNT_W-1:0] free_count_q, free_count_d;

    logic [2:0]       req_cnt_s;
    logic [2:0]       commit_cnt_s;
    logic [2:0]       free_cnt_s;
    logic             alloc_ready_s;
    logic [PTR_W-1:0] rd_idx_s [4];
    logic [PTR_W-1:0] wr_idx_s [4];
    logic [PW-1:0]    alloc_preg_s [4];
    logic [PW-1:0]    free_preg_s [4];

    assign free_preg_s[0] = fl.free_preg_0;
    assign free_preg_s[1] = fl.free_preg_1;
    assign free_preg_s[2] = fl.free_preg_2;
    assign free_preg_s[3] = fl.free_preg_3;

    assign req_cnt_s     = popcnt4(fl.alloc_req_vec);
    assign commit_cnt_s  = popcnt4(fl.commit_rd_vec);
    assign free_cnt_s    = popcnt4(fl.free_vec);
    // Registered count only, so entries released this cycle are invisible until the next.
    assign alloc_ready_s = (free_count_q >= CNT_W'(req_cnt_s));

    // Compacted read-out: requesting lanes index by rank, idle lanes by slot position
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            if (fl.alloc_req_vec[l]) begin
                rd_idx_s[l] = idx_add(head_q.idx, popcnt4(fl.alloc_req_vec & below(l)));
            end else begin
                rd_idx_s[l] = idx_add(head_q.idx, 3'(l));
            end
            alloc_preg_s[l] = entries_q[rd_idx_s[l]];
        end
    end

    // Compacted release: the n-th releasing lane writes entry[tail+n]
    always_comb begin
        entries_d = entries_q;
        for (int l = 0; l < 4; l++) begin
            wr_idx_s[l] = idx_add(tail_q.idx, popcnt4(fl.free_vec & below(l)));
            entries_d[wr_idx_s[l]] = fl.free_vec[l] ? free_preg_s[l] : entries_d[wr_idx_s[l]];
        end
    end

    // Pointer update; recovery rewinds the speculative head to the committed point
    always_comb begin
        arch_head_d = ptr_add(arch_head_q, commit_cnt_s);
        tail_d      = ptr_add(tail_q, free_cnt_s);
        if (fl.recover_valid) begin
            head_d = arch_head_d;
        end else if (alloc_ready_s) begin
            head_d = ptr_add(head_q, req_cnt_s);
        end else begin
            head_d = head_q;
        end
        free_count_d = ptr_dist(tail_d, head_d);
    end

    // State registers; storage reloads the post-architectural preg numbers on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                entries_q[i] <= PW'(ARCH_REG_NUM + i);
            end
            head_q       <= '0;
            arch_head_q  <= '0;
            tail_q       <= {1'b1, {PTR_W{1'b0}}};
            free_count_q <= CNT_W'(FL_DEPTH);
        end else begin
            entries_q    <= entries_d;
            head_q       <= head_d;
            arch_head_q  <= arch_head_d;
            tail_q       <= tail_d;
            free_count_q <= free_count_d;
        end
    end

    assign fl.alloc_ready  = alloc_ready_s;
    assign fl.free_count   = free_count_q;
    assign fl.alloc_preg_0 = alloc_preg_s[0];
    assign fl.alloc_preg_1 = alloc_preg_s[1];
    assign fl.alloc_preg_2 = alloc_preg_s[2];
    assign fl.alloc_preg_3 = alloc_preg_s[3];

`ifdef FREE_LIST_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where a request was refused; recovery leaves it alone
    always_comb begin
        if ((fl.alloc_req_vec != 4'b0000) && !alloc_ready_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fl.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_free_list.sv
// Table-driven bench for free_list (PRF_NUM=64, ARCH_REG_NUM=32) with a free_count scoreboard.
module tb_free_list;
    localparam int ARCH = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    free_list_if #(.ARCH_REG_NUM(ARCH)) fl_if ();
    free_list #(.ARCH_REG_NUM(ARCH)) dut (.clk(clk), .rst_n(rst_n), .fl(fl_if));

    typedef struct {
        bit              do_rst;
        logic [3:0]      req;
        logic [3:0]      commit;
        logic [3:0]      free;
        logic [3:0][5:0] fp;
        logic            rec;
        logic            exp_ready;
        logic [3:0]      chk_mask;
        logic [3:0][5:0] exp_preg;
        int              exp_count;
    } vec_t;

    vec_t vecs[$];
    int   exp_q[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic vec_t mk(bit rst, logic [3:0] req, logic [3:0] commit, logic [3:0] free,
                                int f0, int f1, int f2, int f3, logic rec, logic rdy,
                                logic [3:0] mask, int p0, int p1, int p2, int p3, int cnt);
        vec_t v;
        v.do_rst = rst; v.req = req; v.commit = commit; v.free = free; v.rec = rec;
        v.fp[0] = 6'(f0); v.fp[1] = 6'(f1); v.fp[2] = 6'(f2); v.fp[3] = 6'(f3);
        v.exp_ready = rdy; v.chk_mask = mask;
        v.exp_preg[0] = 6'(p0); v.exp_preg[1] = 6'(p1); v.exp_preg[2] = 6'(p2); v.exp_preg[3] = 6'(p3);
        v.exp_count = cnt;
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int preg_of(input int lane);
        case (lane)
            0:       return int'(fl_if.alloc_preg_0);
            1:       return int'(fl_if.alloc_preg_1);
            2:       return int'(fl_if.alloc_preg_2);
            default: return int'(fl_if.alloc_preg_3);
        endcase
    endfunction

    task automatic drive(input logic [3:0] req, input logic [3:0] commit, input logic [3:0] free,
                         input logic [3:0][5:0] fp, input logic rec);
        fl_if.alloc_req_vec = req;
        fl_if.commit_rd_vec = commit;
        fl_if.free_vec      = free;
        fl_if.free_preg_0   = fp[0];
        fl_if.free_preg_1   = fp[1];
        fl_if.free_preg_2   = fp[2];
        fl_if.free_preg_3   = fp[3];
        fl_if.recover_valid = rec;
    endtask

    task automatic do_reset();
        drive(4'b0000, 4'b0000, 4'b0000, '0, 1'b0);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("rst count", fl_if.free_count, 32);
        check("rst ready", fl_if.alloc_ready, 1);
        for (int l = 0; l < 4; l++) check($sformatf("rst preg%0d", l), preg_of(l), ARCH + l);
    endtask

    task automatic apply(input vec_t v, input int idx);
        if (v.do_rst) do_reset();
        drive(v.req, v.commit, v.free, v.fp, v.rec);
        #2;
        check($sformatf("v%0d ready", idx), fl_if.alloc_ready, v.exp_ready);
        for (int l = 0; l < 4; l++) begin
            if (v.chk_mask[l]) check($sformatf("v%0d preg%0d", idx, l), preg_of(l), v.exp_preg[l]);
        end
        exp_q.push_back(v.exp_count);
        @(posedge clk);
        #1;
        check($sformatf("v%0d count", idx), fl_if.free_count, exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Fill to empty, block, then release-and-request in the same cycle
        vecs.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1, 4'b1111, 32, 33, 34, 35, 28));
        for (int k = 1; k < 8; k++)
            vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1, 4'b1111,
                              32 + 4*k, 33 + 4*k, 34 + 4*k, 35 + 4*k, 28 - 4*k));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0011, 5, 9, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1, 4'b0001, 5, 0, 0, 0, 1));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1, 4'b0001, 9, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0, 0));
        // Sparse request patterns are compacted by rank
        vecs.push_back(mk(1, 4'b1010, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1, 4'b1010, 0, 32, 0, 33, 30));
        vecs.push_back(mk(0, 4'b0110, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1, 4'b0110, 0, 34, 35, 0, 28));
        vecs.push_back(mk(0, 4'b1001, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1, 4'b1001, 36, 0, 0, 37, 26));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b1010, 0, 3, 0, 4, 0, 1, 4'b0100, 0, 0, 38, 0, 27));
        // Allocate 12, commit 4, then recover with 2 more commits plus a release
        vecs.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1, 4'b1111, 32, 33, 34, 35, 28));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1, 4'b1111, 36, 37, 38, 39, 24));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1, 4'b1111, 40, 41, 42, 43, 20));
        vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0, 20));
        vecs.push_back(mk(0, 4'b1111, 4'b0011, 4'b0100, 0, 0, 7, 0, 1, 1, 4'b0000, 0, 0, 0, 0, 27));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1, 4'b0001, 38, 0, 0, 0, 26));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1, 4'b1111, 39, 40, 41, 42, 22));

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Reset asserted while requests and releases are in flight
        drive(4'b1111, 4'b0000, 4'b1111, {6'd1, 6'd2, 6'd3, 6'd4}, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst async count", fl_if.free_count, 32);
        repeat (2) @(posedge clk);
        #1;
        check("midrst held count", fl_if.free_count, 32);
        check("midrst held preg0", preg_of(0), 32);
        #2 rst_n = 1'b1;
        #1;
        check("midrst release preg3", preg_of(3), 35);
        drive(4'b0000, 4'b0000, 4'b0000, '0, 1'b0);
        @(posedge clk);
        #1;
        check("midrst after count", fl_if.free_count, 32);

`ifdef FREE_LIST_PERF_CNT_EN
        do_reset();
        check("stall reset", fl_if.stall_cnt, 0);
        repeat (8) begin
            drive(4'b1111, 4'b0000, 4'b0000, '0, 1'b0);
            @(posedge clk);
            #1;
        end
        check("stall none", fl_if.stall_cnt, 0);
        repeat (3) begin
            drive(4'b0001, 4'b0000, 4'b0000, '0, 1'b0);
            @(posedge clk);
            #1;
        end
        check("stall three", fl_if.stall_cnt, 3);
        drive(4'b0000, 4'b0000, 4'b0000, '0, 1'b1);
        @(posedge clk);
        #1;
        drive(4'b0000, 4'b0000, 4'b0000, '0, 1'b0);
        check("stall after recover", fl_if.stall_cnt, 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameter ARCH_REG_NUM, default 32: number of architectural registers; physical registers 0..ARCH_REG_NUM-1 hold the initial architectural mapping.
REQ-002 Derived FL_DEPTH = `PRF_NUM - ARCH_REG_NUM; indices are `PREG_INDEX_WIDTH bits wide, from defs.sv.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 alloc_req_vec  in  4  rename lanes needing a destination preg this cycle.
REQ-006 alloc_ready  out  1  free_count >= popcount(alloc_req_vec).
REQ-007 alloc_preg_0..3  out  `PREG_INDEX_WIDTH each  allocated preg per lane, combinational.
REQ-008 commit_rd_vec  in  4  committing instructions that own a destination.
REQ-009 free_vec  in  4  lanes releasing an old preg at commit.
REQ-010 free_preg_0..3  in  `PREG_INDEX_WIDTH each  old pregs to return.
REQ-011 recover_valid  in  1  flush on exception or branch mispredict.
REQ-012 free_count  out  $clog2(FL_DEPTH)+1  registered number of free entries.

Function
REQ-013 Storage is a circular FIFO of FL_DEPTH entries with speculative head, architectural head and tail pointers, each carrying one wrap bit.
REQ-014 free_count = tail - head, modulo 2*FL_DEPTH.
REQ-015 Allocation is compacted: the n-th requesting lane in ascending lane order gets entry[head+n]; non-requesting lanes output entry[head+n] of their slot position, value don't-care.
REQ-016 Allocation is all-or-nothing: when alloc_ready=1 and recover_valid=0, head advances by popcount(alloc_req_vec); otherwise head holds.
REQ-017 Release is compacted: the n-th set bit of free_vec writes its free_preg to entry[tail+n]; tail advances by popcount(free_vec) every cycle, including recover cycles.
REQ-018 Architectural head advances by popcount(commit_rd_vec) every cycle, including recover cycles.
REQ-019 On recover_valid=1: head <= architectural head + popcount(commit_rd_vec); allocation is suppressed that cycle.
REQ-020 Pregs released in cycle N are not allocatable before cycle N+1; alloc_ready uses the registered free_count only.
REQ-021 Pointer wrap from FL_DEPTH-1 to 0 toggles the wrap bit; full (free_count=FL_DEPTH) and empty (free_count=0) are distinguished solely by the wrap bit.
REQ-022 Releasing more than FL_DEPTH-free_count entries is a protocol violation; behaviour is undefined.
REQ-023 Request popcount 0 always yields alloc_ready=1 with no state change.

Reset
REQ-024 On rst_n low, asynchronously: entry[i] = ARCH_REG_NUM+i, head = architectural head = 0, tail = FL_DEPTH with wrap bit 1.
REQ-025 After reset: free_count = FL_DEPTH, alloc_ready = 1, alloc_preg_0..3 = ARCH_REG_NUM..ARCH_REG_NUM+3.
REQ-026 Reset released mid-stream discards all in-flight requests; no allocation occurs during reset.

Configuration
REQ-027 With FREE_LIST_PERF_CNT_EN defined: add output stall_cnt (out, 32) counting cycles with alloc_req_vec nonzero and alloc_ready=0, saturating at 2^32-1, reset to 0, not cleared by recover.
REQ-028 Without FREE_LIST_PERF_CNT_EN: the stall_cnt port and its logic are absent; all other behaviour is identical.

Verification
All scenarios use `PRF_NUM=64 and ARCH_REG_NUM=32.
REQ-029 Reset, then alloc_req_vec=4'b1111 -> alloc_preg_0..3 = 32,33,34,35; next cycle free_count = 28.
REQ-030 After reset, alloc_req_vec=4'b1010 -> lane1 gets 32 and lane3 gets 33; free_count = 30.
REQ-031 Eight cycles of 4'b1111 -> free_count = 0; ninth request 4'b0001 -> alloc_ready = 0, head unchanged.
REQ-032 At free_count=0, free_vec=4'b0011 with pregs 5 and 9 and alloc_req_vec=4'b0001 in the same cycle -> no grant that cycle; the next cycle lane0 gets 5.
REQ-033 Allocate 12, commit 4 (commit_rd_vec=4'b1111), then recover_valid with commit_rd_vec=4'b0011 in the same cycle -> next cycle free_count = 26 and alloc_preg_0 = 38.
REQ-034 With FREE_LIST_PERF_CNT_EN defined: 3 blocked request cycles -> stall_cnt = 3; a recover follows -> stall_cnt stays 3.
